// File: rtl/organ_pkg.sv
// Shared types and sizes for the voice allocator that feeds the 8-voice harmonizer.
// Contents: slot geometry, FSM state encoding, the voice slot record and the steal-priority compare.
// Build option: VOICE_ALLOC_SUSTAIN_EN (sustain pedal support) is consumed by voice_allocator.
package organ_pkg;

   localparam int unsigned NUM_VOICES = 8;
   localparam int unsigned NOTE_W     = 7;
   localparam int unsigned AGE_W      = 16;
   localparam int unsigned IDX_W      = $clog2(NUM_VOICES);

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic              busy;
      logic [AGE_W-1:0]  age;
      logic              released;
   } voice_t;

   // True when a is a better steal victim than b: released slots first, then the greater age.
   function automatic logic is_older(input voice_t a, input voice_t b);
      if (a.released != b.released) begin
         return a.released;
      end
      return (a.age > b.age);
   endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the event source (master) and the voice allocator (slave).
// Signals: ev_valid/ev_ready handshake, ev_on (1 = note-on), ev_note (note code, 0 = rest).
interface voice_allocator_if;
   import organ_pkg::*;

   logic              ev_valid;
   logic              ev_ready;
   logic              ev_on;
   logic [NOTE_W-1:0] ev_note;

   modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
   modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);

endinterface

// File: rtl/voice_slot.sv
// One voice slot: note code, busy and released flags, and a saturating age counter.
// Ports: clk, rst (sync, active-high), clear (panic), wr_en + wr_* (commit write),
//        sus_clear (drop this slot if it is released), slot (current slot record).
module voice_slot
   import organ_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [NOTE_W-1:0] wr_note,
   input  logic              wr_busy,
   input  logic              wr_rel,
   input  logic              wr_age_zero,
   input  logic              sus_clear,
   output voice_t            slot
);

   voice_t           slot_q;
   logic [AGE_W-1:0] age_inc;

   // Saturating increment so a long-held note never wraps back to "young".
   assign age_inc = (&slot_q.age) ? slot_q.age : slot_q.age + AGE_W'(1);

   // Slot register: reset/panic, then commit write, then sustain release, then ageing.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         slot_q <= '0;
      end else if (wr_en) begin
         slot_q.note     <= wr_note;
         slot_q.busy     <= wr_busy;
         slot_q.released <= wr_rel;
         slot_q.age      <= (wr_age_zero || !wr_busy) ? '0 : age_inc;
      end else if (sus_clear && slot_q.released) begin
         slot_q <= '0;
      end else if (slot_q.busy) begin
         slot_q.age <= age_inc;
      end else begin
         slot_q.age <= '0;
      end
   end

   assign slot = slot_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: assigns note-on/note-off events to NUM_VOICES harmonizer slots,
// stealing the oldest voice when all slots are busy.
// Ports: clk, rst (sync, active-high), ev (event handshake, slave side), panic,
//        note_out (slot i at [i*NOTE_W +: NOTE_W]), voice_busy, steal_pulse,
//        sustain (only when VOICE_ALLOC_SUSTAIN_EN is defined).
// Each accepted event is scanned one slot per cycle, then committed; 10 cycles per event.
module voice_allocator
   import organ_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic                         sustain,
`endif
   voice_allocator_if.slave             ev,
   input  logic                         panic,
   output logic [NUM_VOICES*NOTE_W-1:0] note_out,
   output logic [NUM_VOICES-1:0]        voice_busy,
   output logic                         steal_pulse
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              on_q, on_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              match_found_q, match_found_d;
   logic [IDX_W-1:0]  match_idx_q, match_idx_d;
   logic              free_found_q, free_found_d;
   logic [IDX_W-1:0]  free_idx_q, free_idx_d;
   logic              old_found_q, old_found_d;
   logic [IDX_W-1:0]  old_idx_q, old_idx_d;
   logic              steal_q, steal_d;

   voice_t                  slots [NUM_VOICES];
   voice_t                  cur, oldv;
   logic [NUM_VOICES-1:0]   wr_en;
   logic [NOTE_W-1:0]       wr_note;
   logic                    wr_busy, wr_rel, wr_age_zero;
   logic                    sus_clear, sus_hold;
   logic                    accept;

   assign ev.ev_ready = (state_q == IDLE) && !panic && !rst;
   assign accept      = ev.ev_valid && ev.ev_ready;

`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic sus_q, pend_q, sus_fall;

   assign sus_fall  = sus_q && !sustain;
   assign sus_hold  = sustain;
   // Release clear only fires in IDLE so the scan never sees slots vanish mid-event.
   assign sus_clear = (state_q == IDLE) && (pend_q || sus_fall) && !panic;

   // Sustain edge detect and deferred-clear flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         sus_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         sus_q <= sustain;
         if (panic || (state_q == IDLE)) begin
            pend_q <= 1'b0;
         end else if (sus_fall) begin
            pend_q <= 1'b1;
         end
      end
   end
`else
   assign sus_hold  = 1'b0;
   assign sus_clear = 1'b0;
`endif

   // Next-state, scan tracking and commit write controls.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      on_d          = on_q;
      note_d        = note_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
      old_found_d   = old_found_q;
      old_idx_d     = old_idx_q;
      steal_d       = 1'b0;
      wr_en         = '0;
      wr_note       = note_q;
      wr_busy       = 1'b0;
      wr_rel        = 1'b0;
      wr_age_zero   = 1'b0;
      cur           = slots[idx_q];
      oldv          = slots[old_idx_q];

      unique case (state_q)
         IDLE: begin
            // A rest-coded event is consumed here with no effect.
            if (accept && (ev.ev_note != NOTE_REST)) begin
               on_d          = ev.ev_on;
               note_d        = ev.ev_note;
               idx_d         = '0;
               match_found_d = 1'b0;
               match_idx_d   = '0;
               free_found_d  = 1'b0;
               free_idx_d    = '0;
               old_found_d   = 1'b0;
               old_idx_d     = '0;
               state_d       = SCAN;
            end
         end
         SCAN: begin
            if (cur.busy && (cur.note == note_q) && !match_found_q) begin
               match_found_d = 1'b1;
               match_idx_d   = idx_q;
            end
            if (!cur.busy && !free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end
            // Compare live ages of both candidates; all busy ages advance together.
            if (cur.busy && (!old_found_q || is_older(cur, oldv))) begin
               old_found_d = 1'b1;
               old_idx_d   = idx_q;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (on_q) begin
               wr_busy     = 1'b1;
               wr_age_zero = 1'b1;
               if (match_found_q) begin
                  wr_en[match_idx_q] = 1'b1;
               end else if (free_found_q) begin
                  wr_en[free_idx_q] = 1'b1;
               end else if (old_found_q) begin
                  wr_en[old_idx_q] = 1'b1;
                  steal_d          = 1'b1;
               end
            end else if (match_found_q) begin
               wr_en[match_idx_q] = 1'b1;
               if (sus_hold) begin
                  wr_busy = 1'b1;
                  wr_rel  = 1'b1;
               end else begin
                  wr_note = NOTE_REST;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and scan result registers; panic drops any in-flight event.
   always_ff @(posedge clk) begin
      if (rst || panic) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         on_q          <= 1'b0;
         note_q        <= NOTE_REST;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         old_found_q   <= 1'b0;
         old_idx_q     <= '0;
         steal_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         on_q          <= on_d;
         note_q        <= note_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         old_found_q   <= old_found_d;
         old_idx_q     <= old_idx_d;
         steal_q       <= steal_d;
      end
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      voice_slot u_slot (
         .clk         (clk),
         .rst         (rst),
         .clear       (panic),
         .wr_en       (wr_en[i]),
         .wr_note     (wr_note),
         .wr_busy     (wr_busy),
         .wr_rel      (wr_rel),
         .wr_age_zero (wr_age_zero),
         .sus_clear   (sus_clear),
         .slot        (slots[i])
      );
      assign note_out[i*NOTE_W +: NOTE_W] = slots[i].note;
      assign voice_busy[i]                = slots[i].busy;
   end

   assign steal_pulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a behavioural slot model predicts the slot
// map for every accepted event and queues it for comparison 10 cycles later.
module tb_voice_allocator;
   import organ_pkg::*;

   localparam int unsigned OUT_W = NUM_VOICES * NOTE_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             panic;
   logic [OUT_W-1:0] note_out;
   logic [NUM_VOICES-1:0] voice_busy;
   logic             steal_pulse;
   logic             sus_now;
`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic             sustain;
   assign sus_now = sustain;
`else
   assign sus_now = 1'b0;
`endif

   voice_allocator_if ev ();

   voice_allocator dut (
      .clk         (clk),
      .rst         (rst),
`ifdef VOICE_ALLOC_SUSTAIN_EN
      .sustain     (sustain),
`endif
      .ev          (ev),
      .panic       (panic),
      .note_out    (note_out),
      .voice_busy  (voice_busy),
      .steal_pulse (steal_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      int                    due;
      logic [OUT_W-1:0]      notes;
      logic [NUM_VOICES-1:0] busy;
      logic                  steal;
   } exp_t;

   exp_t sb[$];
   logic mon_en = 1'b0;

   // Reference slot model: timestamps of last (re)trigger stand in for ages.
   logic [NOTE_W-1:0] m_note [NUM_VOICES];
   logic              m_busy [NUM_VOICES];
   logic              m_rel  [NUM_VOICES];
   int                m_ts   [NUM_VOICES];

   function automatic void model_clear();
      for (int i = 0; i < NUM_VOICES; i++) begin
         m_note[i] = '0; m_busy[i] = 1'b0; m_rel[i] = 1'b0; m_ts[i] = 0;
      end
   endfunction

   function automatic void model_release_clear();
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (m_rel[i]) begin
            m_note[i] = '0; m_busy[i] = 1'b0; m_rel[i] = 1'b0;
         end
      end
   endfunction

   function automatic logic model_event(input logic on, input logic [NOTE_W-1:0] n,
                                        input logic sus, input int now);
      int match = -1;
      int free  = -1;
      int old   = -1;
      if (n == '0) return 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (m_busy[i] && m_note[i] == n && match < 0) match = i;
         if (!m_busy[i] && free < 0) free = i;
         if (m_busy[i] && (old < 0 || (m_rel[i] && !m_rel[old]) ||
                           (m_rel[i] == m_rel[old] && m_ts[i] < m_ts[old]))) old = i;
      end
      if (on) begin
         if (match >= 0) begin
            m_ts[match] = now; m_rel[match] = 1'b0;
         end else if (free >= 0) begin
            m_note[free] = n; m_busy[free] = 1'b1; m_rel[free] = 1'b0; m_ts[free] = now;
         end else begin
            m_note[old] = n; m_rel[old] = 1'b0; m_ts[old] = now;
            return 1'b1;
         end
      end else if (match >= 0) begin
         if (sus) m_rel[match] = 1'b1;
         else begin
            m_note[match] = '0; m_busy[match] = 1'b0; m_rel[match] = 1'b0;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [OUT_W-1:0] model_notes();
      logic [OUT_W-1:0] v;
      for (int i = 0; i < NUM_VOICES; i++) v[i*NOTE_W +: NOTE_W] = m_note[i];
      return v;
   endfunction

   function automatic logic [NUM_VOICES-1:0] model_busy();
      logic [NUM_VOICES-1:0] v;
      for (int i = 0; i < NUM_VOICES; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Scoreboard consumer and per-cycle steal_pulse check.
   always @(negedge clk) begin
      exp_t e;
      logic exp_steal;
      exp_steal = 1'b0;
      if (mon_en && sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("notes", 64'(note_out), 64'(e.notes));
         check("busy", 64'(voice_busy), 64'(e.busy));
         check("ready_at_result", 64'(ev.ev_ready), 64'd1);
         exp_steal = e.steal;
      end
      if (mon_en) check("steal", 64'(steal_pulse), 64'(exp_steal));
   end

   // Present an event at a negedge, wait for acceptance, queue the predicted result.
   task automatic send(input logic on, input logic [NOTE_W-1:0] n, input logic keep,
                       output int acc);
      exp_t e;
      int   k;
      ev.ev_valid = 1'b1; ev.ev_on = on; ev.ev_note = n;
      #1;
      k = 0;
      while (!ev.ev_ready && k < 40) begin
         @(negedge clk); #1; k++;
      end
      if (!ev.ev_ready) begin
         check("accept_timeout", 64'(ev.ev_ready), 64'd1);
         ev.ev_valid = 1'b0;
         acc = -1;
         return;
      end
      acc     = cyc;
      e.steal = model_event(on, n, sus_now, acc);
      e.due   = acc + 10;
      e.notes = model_notes();
      e.busy  = model_busy();
      sb.push_back(e);
      @(negedge clk);
      if (!keep) ev.ev_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() > 0 && k < 200) begin
         @(negedge clk); k++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic do_panic();
      panic = 1'b1;
      #1;
      check("ready_in_panic", 64'(ev.ev_ready), 64'd0);
      sb.delete();
      model_clear();
      @(negedge clk);
      check("panic_notes", 64'(note_out), 64'd0);
      check("panic_busy", 64'(voice_busy), 64'd0);
      panic = 1'b0;
      #1;
      check("ready_after_panic", 64'(ev.ev_ready), 64'd1);
   endtask

   initial begin
      int a0, a1, a2, a3, acc;
      rst = 1'b1; panic = 1'b0;
      ev.ev_valid = 1'b0; ev.ev_on = 1'b0; ev.ev_note = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      sustain = 1'b0;
`endif
      model_clear();
      @(negedge clk); #1;
      check("ready_in_reset", 64'(ev.ev_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_notes", 64'(note_out), 64'd0);
      check("rst_busy", 64'(voice_busy), 64'd0);
      check("rst_steal", 64'(steal_pulse), 64'd0);
      check("rst_ready", 64'(ev.ev_ready), 64'd1);
      mon_en = 1'b1;

      // Three note-ons land in slots 0..2.
      send(1'b1, 7'd60, 1'b0, acc);
      send(1'b1, 7'd64, 1'b0, acc);
      send(1'b1, 7'd67, 1'b0, acc);
      drain();
      check("t1_busy", 64'(voice_busy), 64'h07);
      check("t1_slot2", 64'(note_out[2*NOTE_W +: NOTE_W]), 64'd67);

      // Fill all slots, then steal the oldest twice.
      do_panic();
      for (int n = 60; n <= 67; n++) send(1'b1, NOTE_W'(n), 1'b0, acc);
      drain();
      repeat (5) @(negedge clk);
      send(1'b1, 7'd72, 1'b0, acc);
      send(1'b1, 7'd73, 1'b0, acc);
      drain();
      check("t2_slot0", 64'(note_out[0 +: NOTE_W]), 64'd72);
      check("t2_slot1", 64'(note_out[NOTE_W +: NOTE_W]), 64'd73);
      check("t2_busy", 64'(voice_busy), 64'hFF);

      // Note-off, unmatched off, retrigger; the retrigger makes slot 1 the steal victim.
      do_panic();
      send(1'b1, 7'd60, 1'b0, acc);
      send(1'b1, 7'd64, 1'b0, acc);
      send(1'b0, 7'd64, 1'b0, acc);
      drain();
      check("t3_off_busy", 64'(voice_busy), 64'h01);
      send(1'b0, 7'd50, 1'b0, acc);
      send(1'b1, 7'd62, 1'b0, acc);
      send(1'b1, 7'd60, 1'b0, acc);
      drain();
      check("t3_retrig_busy", 64'(voice_busy), 64'h03);
      for (int n = 70; n <= 75; n++) send(1'b1, NOTE_W'(n), 1'b0, acc);
      send(1'b1, 7'd80, 1'b0, acc);
      drain();
      check("t3_victim", 64'(note_out[NOTE_W +: NOTE_W]), 64'd80);
      check("t3_keep60", 64'(note_out[0 +: NOTE_W]), 64'd60);

      // Panic in the middle of a scan drops the in-flight event.
      do_panic();
      send(1'b1, 7'd60, 1'b0, acc);
      send(1'b1, 7'd64, 1'b0, acc);
      send(1'b1, 7'd67, 1'b0, acc);
      drain();
      send(1'b1, 7'd70, 1'b0, acc);
      repeat (2) @(negedge clk);
      do_panic();
      repeat (12) @(negedge clk);
      check("t4_dropped_notes", 64'(note_out), 64'd0);
      check("t4_dropped_busy", 64'(voice_busy), 64'd0);

      // Back-to-back events with valid held high; then a rest-coded event.
      send(1'b1, 7'd50, 1'b1, a0);
      send(1'b0, 7'd50, 1'b1, a1);
      send(1'b1, 7'd51, 1'b1, a2);
      send(1'b0, 7'd51, 1'b0, a3);
      check("t5_gap01", 64'(a1 - a0), 64'd10);
      check("t5_gap12", 64'(a2 - a1), 64'd10);
      check("t5_gap23", 64'(a3 - a2), 64'd10);
      drain();
      send(1'b1, 7'd55, 1'b0, acc);
      drain();
      send(1'b1, 7'd0, 1'b0, acc);
      check("t5_rest_ready", 64'(ev.ev_ready), 64'd1);
      drain();
      check("t5_rest_nochange", 64'(note_out), 64'd55);

`ifdef VOICE_ALLOC_SUSTAIN_EN
      // Sustained note-off keeps sounding until the pedal is released.
      do_panic();
      sustain = 1'b1;
      send(1'b1, 7'd60, 1'b0, acc);
      send(1'b0, 7'd60, 1'b0, acc);
      drain();
      check("sus_held_note", 64'(note_out[0 +: NOTE_W]), 64'd60);
      check("sus_held_busy", 64'(voice_busy), 64'h01);
      sustain = 1'b0;
      @(negedge clk);
      model_release_clear();
      check("sus_release_note", 64'(note_out), 64'd0);
      check("sus_release_busy", 64'(voice_busy), 64'd0);
      // Pedal released mid-event: clear waits for the event to finish.
      sustain = 1'b1;
      send(1'b1, 7'd63, 1'b0, acc);
      send(1'b0, 7'd63, 1'b0, acc);
      send(1'b1, 7'd64, 1'b0, acc);
      sustain = 1'b0;
      drain();
      @(negedge clk);
      model_release_clear();
      check("sus_defer_note", 64'(note_out), 64'(7'd64) << NOTE_W);
      check("sus_defer_busy", 64'(voice_busy), 64'h02);
`endif

      drain();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
